acsp_top: RTL and testbench
===========================

ACSP_TOP -- requirements
Module: acsp_top

Interface
REQ-001 The block SHALL have parameter CLK_FREQ_HZ, default 100_000_000, system clock frequency.
REQ-002 The block SHALL have parameter BAUD_RATE, default 9600, UART bit rate.
REQ-003 The block SHALL have parameter DEPTH, default 16, number of capture samples (power of two, 2..256).
REQ-004 The block SHALL have port system_clock, input, 1 bit, the single clock for all logic.
REQ-005 The block SHALL have port ext_reset, input, 1 bit, reset that is asynchronous and active-low.
REQ-006 The block SHALL have port dataToSample, input, 8 bits, the logic probes, asynchronous to system_clock.
REQ-007 The block SHALL have port rx, input, 1 bit, UART receive line, idle high.
REQ-008 The block SHALL have port tx, output, 1 bit, UART transmit line, idle high.

Function
REQ-009 UART SHALL use 8N1 framing, LSB first, with bit period = round(CLK_FREQ_HZ/BAUD_RATE) clocks (10417 at defaults).
REQ-010 rx SHALL pass through a 2-flop synchronizer; each bit SHALL be sampled at mid-bit, timed from the start-bit falling edge.
REQ-011 A start bit SHALL be rejected if rx reads high at mid-start; a frame with stop bit low SHALL be discarded.
REQ-012 Each received byte SHALL assert a 1-cycle byte-valid strobe to the command decoder, at most one clock after the stop-bit sample.
REQ-013 Decoder states: IDLE, LONG_ARGS, CAPTURE, SEND.
REQ-014 In IDLE, opcode 0x00 (reset) SHALL clear pending state and remain in IDLE with no response.
REQ-015 In IDLE, opcode 0x02 (ID) SHALL go to SEND and transmit 0x31 0x41 0x4C 0x53 ("1ALS").
REQ-016 In IDLE, opcode 0x01 (arm) SHALL go to CAPTURE.
- Capture SHALL store synchronized dataToSample on DEPTH consecutive clocks, then go to SEND.
- SEND SHALL transmit the DEPTH samples, last-captured first.
REQ-017 In IDLE, opcode 0x04 (metadata) SHALL behave per REQ-027.
REQ-018 Any opcode at or above 0x80 SHALL go to LONG_ARGS.
- LONG_ARGS SHALL discard exactly 4 further bytes, then return to IDLE.
REQ-019 Any other opcode below 0x80 SHALL be ignored.
REQ-020 In SEND, transmit bytes SHALL be back-to-back, with one stop bit and no extra idle between frames.
- After the last byte's stop bit, the decoder SHALL return to IDLE.
REQ-021 A received 0x00 during CAPTURE or SEND SHALL abort the operation.
- tx SHALL finish the frame in progress, then idle; the decoder SHALL return to IDLE.
REQ-022 All other bytes received during CAPTURE or SEND SHALL be ignored.
REQ-023 A byte received while in LONG_ARGS SHALL count as an argument even if it equals 0x00.
REQ-024 Sample memory SHALL wrap at DEPTH; the response length SHALL be exactly DEPTH bytes.

Reset
REQ-025 While ext_reset is low, the block SHALL hold the following values:
- tx = 1
- decoder in IDLE
- UART receiver and transmitter idle
- all counters = 0
REQ-026 Reset asserted mid-frame SHALL abort immediately.
- Reception SHALL restart only at the next start bit after ext_reset goes high.
- Memory contents need not be cleared.

Configuration
REQ-027 With macro ACSP_METADATA_EN defined, opcode 0x04 SHALL go to SEND and transmit these 14 bytes:
- 0x01 0x41 0x43 0x53 0x50 0x00 (name "ACSP")
- 0x21 followed by DEPTH as a 32-bit big-endian value
- 0x40 0x08 0x00
REQ-028 Without ACSP_METADATA_EN defined, opcode 0x04 SHALL be ignored like an unknown short opcode, and no metadata ROM SHALL be synthesized.

Structure
REQ-029 Package acsp_pkg SHALL hold:
- opcode constants: 0x00, 0x01, 0x02, 0x04, long-opcode threshold 0x80
- the ID bytes
- the metadata byte constants
- the decoder state enum
REQ-030 UART rx and tx SHALL live in one sub-module, acsp_uart, parameterised by CLK_FREQ_HZ and BAUD_RATE; acsp_top SHALL hold the decoder, capture memory and response sequencer.

Verification
REQ-031 Pulse ext_reset low, release, send 0x02 -> tx carries 0x31 0x41 0x4C 0x53, 8N1 at 9600 baud.
REQ-032 With ACSP_METADATA_EN defined, send 0x04 -> exactly 14 bytes, ending 0x21 00 00 00 10 40 08 00.
- Follow with five 0x00 bytes -> no tx activity.
- Without the macro, send 0x04 -> tx stays high.
REQ-033 dataToSample = 0xFF, send 0x01 -> 16 bytes of 0xFF on tx.
REQ-034 Send 0x81 0x02 0x02 0x02 0x02, then 0x02 -> only the "1ALS" response (args not decoded as ID).
REQ-035 Send 0x01, then 0x00 during the third response byte -> that byte completes, nothing further is sent.
- A subsequent 0x02 is answered normally.
REQ-036 Send a frame with stop bit 0 carrying 0x02 -> no response.
- Assert reset mid-byte, then send 0x02 -> normal response.

Source files
------------

// File: rtl/acsp_pkg.sv
// Shared constants and types for the ACSP logic-capture probe: opcodes,
// response byte tables and the state enums used by the decoder and UART.
package acsp_pkg;

  localparam logic [7:0] OP_RESET    = 8'h00;
  localparam logic [7:0] OP_ARM      = 8'h01;
  localparam logic [7:0] OP_ID       = 8'h02;
  localparam logic [7:0] OP_META     = 8'h04;
  localparam logic [7:0] OP_LONG_MIN = 8'h80;

  localparam int         LONG_ARG_COUNT = 4;

  localparam int         ID_LEN = 4;
  localparam logic [7:0] ID_BYTES [ID_LEN] = '{8'h31, 8'h41, 8'h4C, 8'h53};

  localparam int         META_LEN = 14;
  localparam logic [7:0] META_NAME [6] = '{8'h01, 8'h41, 8'h43, 8'h53, 8'h50, 8'h00};
  localparam logic [7:0] META_TAG_DEPTH = 8'h21;
  localparam logic [7:0] META_TAIL [3] = '{8'h40, 8'h08, 8'h00};

  typedef enum logic [1:0] {IDLE, LONG_ARGS, CAPTURE, SEND} dec_state_e;
  typedef enum logic [1:0] {RESP_ID, RESP_CAP, RESP_META} resp_kind_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // Metadata record: name block, depth as 32-bit big-endian, sample-width block.
  function automatic logic [7:0] meta_byte(input logic [3:0] idx, input logic [31:0] depth);
    logic [7:0] b;
    b = META_TAIL[2];
    case (idx)
      4'd0:    b = META_NAME[0];
      4'd1:    b = META_NAME[1];
      4'd2:    b = META_NAME[2];
      4'd3:    b = META_NAME[3];
      4'd4:    b = META_NAME[4];
      4'd5:    b = META_NAME[5];
      4'd6:    b = META_TAG_DEPTH;
      4'd7:    b = depth[31:24];
      4'd8:    b = depth[23:16];
      4'd9:    b = depth[15:8];
      4'd10:   b = depth[7:0];
      4'd11:   b = META_TAIL[0];
      4'd12:   b = META_TAIL[1];
      default: b = META_TAIL[2];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/acsp_uart.sv
// 8N1 UART receiver and transmitter sharing one bit-period timebase.
// tx_free is high when a new byte may be loaded, including the last clock of a stop bit.
module acsp_uart
  import acsp_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_free,
  output logic       tx
);

  localparam int             BIT_CLKS  = (CLK_FREQ_HZ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int             CW        = $clog2(BIT_CLKS);
  localparam logic [CW-1:0]  BIT_LAST  = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(BIT_CLKS / 2 - 1);

  rx_state_e     rx_state, rx_state_d;
  logic [2:0]    rx_sync;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_tick;
  logic          rx_s;
  logic          rx_fall;

  assign rx_s    = rx_sync[1];
  assign rx_fall = !rx_sync[1] && rx_sync[2];
  assign rx_data = rx_shift;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    rx_state_d = rx_state;
    rx_tick    = 1'b0;
    unique case (rx_state)
      RX_IDLE:  if (rx_fall) rx_state_d = RX_START;
      RX_START: if (rx_cnt == HALF_LAST) begin
        rx_tick    = 1'b1;
        rx_state_d = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA:  if (rx_cnt == BIT_LAST) begin
        rx_tick = 1'b1;
        if (rx_bit == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP:  if (rx_cnt == BIT_LAST) begin
        rx_tick    = 1'b1;
        rx_state_d = RX_IDLE;
      end
      default:  rx_state_d = RX_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_sync  <= 3'b111;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_state <= rx_state_d;
      rx_sync  <= {rx_sync[1:0], rx};
      rx_valid <= 1'b0;
      if (rx_state == RX_IDLE || rx_tick) rx_cnt <= '0;
      else                                rx_cnt <= rx_cnt + 1'b1;
      if (rx_state == RX_IDLE) rx_bit <= '0;
      if (rx_tick && rx_state == RX_DATA) begin
        rx_shift <= {rx_s, rx_shift[7:1]};
        rx_bit   <= rx_bit + 1'b1;
      end
      // A low stop bit drops the frame; the falling-edge detector then waits for the line to recover.
      if (rx_tick && rx_state == RX_STOP) rx_valid <= rx_s;
    end
  end

  logic [9:0]    tx_shift;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic          tx_busy;

  assign tx_free = !tx_busy || (tx_bit == 4'd9 && tx_cnt == BIT_LAST);
  assign tx      = tx_shift[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift <= '1;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_busy  <= 1'b0;
    end else if (tx_start && tx_free) begin
      tx_shift <= {1'b1, tx_data, 1'b0};
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_busy  <= 1'b1;
    end else if (tx_busy) begin
      if (tx_cnt == BIT_LAST) begin
        tx_cnt   <= '0;
        tx_shift <= {1'b1, tx_shift[9:1]};
        tx_bit   <= tx_bit + 1'b1;
        if (tx_bit == 4'd9) tx_busy <= 1'b0;
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/acsp_top.sv
// ACSP logic-capture probe: UART command decoder, DEPTH-sample capture RAM and response sequencer.
// Define ACSP_METADATA_EN to answer opcode 0x04 with the 14-byte metadata record.
module acsp_top
  import acsp_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int DEPTH       = 16
) (
  input  logic       system_clock,
  input  logic       ext_reset,
  input  logic [7:0] dataToSample,
  input  logic       rx,
  output logic       tx
);

  localparam int            AW        = $clog2(DEPTH);
  localparam logic [AW-1:0] CAP_LAST  = AW'(DEPTH - 1);
  localparam logic [8:0]    DEPTH_LEN = 9'(DEPTH);

  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_byte;
  logic       tx_start;
  logic       tx_free;

  acsp_uart #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .BAUD_RATE  (BAUD_RATE)
  ) u_uart (
    .clk     (system_clock),
    .rst_n   (ext_reset),
    .rx      (rx),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_data (tx_byte),
    .tx_start(tx_start),
    .tx_free (tx_free),
    .tx      (tx)
  );

  dec_state_e    state, state_d;
  resp_kind_e    kind, kind_d;
  logic [1:0]    arg_cnt;
  logic [AW-1:0] cap_cnt;
  logic [8:0]    send_idx;
  logic [8:0]    resp_len;
  logic [7:0]    samp_q1, samp_q2;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_addr;
  logic          abort;

  assign abort   = rx_valid && (rx_data == OP_RESET);
  assign rd_addr = CAP_LAST - send_idx[AW-1:0];

  always_comb begin
    state_d  = state;
    kind_d   = kind;
    tx_start = 1'b0;
    unique case (state)
      IDLE: if (rx_valid) begin
        if (rx_data == OP_ID) begin
          state_d = SEND;
          kind_d  = RESP_ID;
        end else if (rx_data == OP_ARM) begin
          state_d = CAPTURE;
`ifdef ACSP_METADATA_EN
        end else if (rx_data == OP_META) begin
          state_d = SEND;
          kind_d  = RESP_META;
`endif
        end else if (rx_data >= OP_LONG_MIN) begin
          state_d = LONG_ARGS;
        end
      end
      // Arguments are counted blindly, so a 0x00 here never aborts.
      LONG_ARGS: if (rx_valid && arg_cnt == 2'(LONG_ARG_COUNT - 1)) state_d = IDLE;
      CAPTURE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cap_cnt == CAP_LAST) begin
          state_d = SEND;
          kind_d  = RESP_CAP;
        end
      end
      SEND: begin
        if (abort)                   state_d  = IDLE;
        else if (tx_free) begin
          if (send_idx == resp_len)  state_d  = IDLE;
          else                       tx_start = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge system_clock or negedge ext_reset) begin
    if (!ext_reset) begin
      state    <= IDLE;
      kind     <= RESP_ID;
      arg_cnt  <= '0;
      cap_cnt  <= '0;
      send_idx <= '0;
      samp_q1  <= '0;
      samp_q2  <= '0;
    end else begin
      state   <= state_d;
      kind    <= kind_d;
      samp_q1 <= dataToSample;
      samp_q2 <= samp_q1;
      if (state != LONG_ARGS) arg_cnt <= '0;
      else if (rx_valid)      arg_cnt <= arg_cnt + 1'b1;
      if (state != CAPTURE)   cap_cnt <= '0;
      else                    cap_cnt <= cap_cnt + 1'b1;
      if (state != SEND)      send_idx <= '0;
      else if (tx_start)      send_idx <= send_idx + 1'b1;
    end
  end

  // NOTE: the sample RAM has no reset so it maps onto plain RAM; every entry is rewritten before it is read.
  always_ff @(posedge system_clock) begin
    if (state == CAPTURE) mem[cap_cnt] <= samp_q2;
  end

  always_comb begin
    tx_byte  = ID_BYTES[send_idx[1:0]];
    resp_len = 9'(ID_LEN);
    case (kind)
      RESP_CAP: begin
        tx_byte  = mem[rd_addr];
        resp_len = DEPTH_LEN;
      end
`ifdef ACSP_METADATA_EN
      RESP_META: begin
        tx_byte  = meta_byte(send_idx[3:0], 32'(DEPTH));
        resp_len = 9'(META_LEN);
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_acsp_top.sv
// Directed bench for acsp_top: drives UART commands on rx, decodes tx with a frame monitor
// and compares the responses against hand-computed byte sequences.
module tb_acsp_top;

  localparam int CLK_HZ = 153_600;
  localparam int BAUD   = 9600;
  localparam int BIT    = 16;
  localparam int DEPTH  = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] probe = 8'h00;
  logic       rx_line = 1'b1;
  logic       tx_line;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_starts = 0;
  int frame_err = 0;
  logic [7:0] resp_q[$];
  int         start_q[$];

  acsp_top #(
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD_RATE  (BAUD),
    .DEPTH      (DEPTH)
  ) dut (
    .system_clock(clk),
    .ext_reset   (rst_n),
    .dataToSample(probe),
    .rx          (rx_line),
    .tx          (tx_line)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // tx frame monitor: samples mid-bit on the falling clock edge.
  initial begin
    logic [7:0] d;
    int t0;
    forever begin
      @(negedge clk);
      if (tx_line == 1'b0) begin
        t0 = cyc;
        n_starts++;
        repeat (BIT / 2) @(negedge clk);
        if (tx_line !== 1'b0) frame_err++;
        for (int b = 0; b < 8; b++) begin
          repeat (BIT) @(negedge clk);
          d[b] = tx_line;
        end
        repeat (BIT) @(negedge clk);
        if (tx_line !== 1'b1) frame_err++;
        resp_q.push_back(d);
        start_q.push_back(t0);
      end
    end
  end

  task automatic uart_send(input logic [7:0] data, input logic stop_bit);
    rx_line = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      rx_line = data[b];
      repeat (BIT) @(negedge clk);
    end
    rx_line = stop_bit;
    repeat (BIT) @(negedge clk);
    rx_line = 1'b1;
  endtask

  task automatic clear_mon();
    resp_q.delete();
    start_q.delete();
  endtask

  // Waits (bounded) for n response bytes, then a quiet window to catch extras.
  task automatic expect_count(input string tag, input int n);
    int budget;
    budget = (n + 4) * 10 * BIT;
    while (resp_q.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    repeat (30 * BIT) @(negedge clk);
    check({tag, " count"}, resp_q.size(), n);
  endtask

  task automatic expect_id(input string tag);
    logic [7:0] id_exp [4];
    id_exp = '{8'h31, 8'h41, 8'h4C, 8'h53};
    expect_count(tag, 4);
    for (int i = 0; i < 4 && i < resp_q.size(); i++)
      check({tag, " byte"}, resp_q[i], id_exp[i]);
  endtask

  initial begin
    logic [7:0] meta_exp [14];
    int base, budget;
    meta_exp = '{8'h01, 8'h41, 8'h43, 8'h53, 8'h50, 8'h00, 8'h21,
                 8'h00, 8'h00, 8'h00, 8'h10, 8'h40, 8'h08, 8'h00};

    // Reset state
    repeat (5) @(negedge clk);
    check("tx in reset", tx_line, 1'b1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("tx after reset", tx_line, 1'b1);

    // ID command, including back-to-back frame spacing
    clear_mon();
    uart_send(8'h02, 1'b1);
    expect_id("id");
    for (int i = 1; i < 4 && i < start_q.size(); i++)
      check("id frame gap", start_q[i] - start_q[i-1], 10 * BIT);

    // Metadata command, then reset opcodes produce nothing
    clear_mon();
    uart_send(8'h04, 1'b1);
`ifdef ACSP_METADATA_EN
    expect_count("meta", 14);
    for (int i = 0; i < 14 && i < resp_q.size(); i++)
      check("meta byte", resp_q[i], meta_exp[i]);
`else
    expect_count("meta disabled", 0);
    check("meta disabled starts", start_q.size(), 0);
`endif
    clear_mon();
    for (int i = 0; i < 5; i++) uart_send(8'h00, 1'b1);
    expect_count("reset opcodes", 0);

    // Capture of constant 0xFF
    clear_mon();
    probe = 8'hFF;
    uart_send(8'h01, 1'b1);
    expect_count("cap ff", DEPTH);
    for (int i = 0; i < DEPTH && i < resp_q.size(); i++)
      check("cap ff byte", resp_q[i], 8'hFF);

    // Capture of a ramp: consecutive samples, last-captured first
    clear_mon();
    probe = 8'h00;
    fork
      uart_send(8'h01, 1'b1);
      for (int k = 0; k < 220; k++) begin
        @(negedge clk);
        probe = probe + 8'd1;
      end
    join
    expect_count("cap ramp", DEPTH);
    for (int i = 1; i < DEPTH && i < resp_q.size(); i++)
      check("cap ramp step", 8'(resp_q[i-1] - resp_q[i]), 8'd1);

    // Long opcode swallows four arguments, including 0x00
    clear_mon();
    uart_send(8'h81, 1'b1);
    for (int i = 0; i < 4; i++) uart_send(8'h02, 1'b1);
    uart_send(8'h02, 1'b1);
    expect_id("long args");
    clear_mon();
    uart_send(8'h80, 1'b1);
    for (int i = 0; i < 4; i++) uart_send(8'h00, 1'b1);
    uart_send(8'h02, 1'b1);
    expect_id("long zero args");

    // Abort during the third response byte
    clear_mon();
    probe = 8'h5A;
    uart_send(8'h01, 1'b1);
    base = n_starts - start_q.size();
    budget = 2000;
    while (n_starts < base + 2 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("abort sync", n_starts >= base + 2, 1'b1);
    repeat (100) @(negedge clk);
    uart_send(8'h00, 1'b1);
    expect_count("abort", 3);
    for (int i = 0; i < 3 && i < resp_q.size(); i++)
      check("abort byte", resp_q[i], 8'h5A);
    clear_mon();
    uart_send(8'h02, 1'b1);
    expect_id("after abort");

    // Frame with a low stop bit is discarded
    clear_mon();
    uart_send(8'h02, 1'b0);
    expect_count("bad stop", 0);

    // Reset mid-byte, held until the line is idle again
    clear_mon();
    fork
      uart_send(8'h02, 1'b1);
      begin
        repeat (4 * BIT) @(negedge clk);
        rst_n = 1'b0;
      end
    join
    repeat (BIT) @(negedge clk);
    check("tx mid reset", tx_line, 1'b1);
    rst_n = 1'b1;
    expect_count("reset mid byte", 0);
    uart_send(8'h02, 1'b1);
    expect_id("after reset");

    check("tx idle at end", tx_line, 1'b1);
    check("frame errors", frame_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
